// File: rtl/seg_pkg.sv
// Shared seven-segment constants, hex glyph table and scanner state type.
package seg_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Control and display signals of the seven-segment scanner.
interface seven_seg_scanner_if;

    logic        en;
    logic        load;
    logic [31:0] value;
    logic [7:0]  digit_mask;
    logic        lz_en;
    logic [6:0]  segments;
    logic [7:0]  anodes;
    logic        frame_done;
    logic        pending;

    modport master (
        output en, load, value, digit_mask, lz_en,
        input  segments, anodes, frame_done, pending
    );

    modport slave (
        input  en, load, value, digit_mask, lz_en,
        output segments, anodes, frame_done, pending
    );

endinterface

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0]       digit,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = HEX_GLYPH[digit];

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with frame-aligned value update.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    seven_seg_scanner_if.slave bus
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    scan_state_e           state_q, state_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [31:0]           pend_reg_q, pend_reg_d;
    logic                  pending_q, pending_d;
    logic                  en_q;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;

    logic [3:0]            nibble;
    logic [SEG_W-1:0]      glyph;
    logic                  lz_zero;
    logic                  suppress;
    logic                  wrap;

    assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

    hex_to_7seg u_hex (
        .digit (nibble),
        .seg_c (glyph)
    );

    // Leading-zero test: every shadow nibble at or above the current digit is zero.
    always_comb begin
        lz_zero = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IDX_W'(i) >= idx_q && shadow_q[4*i +: 4] != 4'h0) begin
                lz_zero = 1'b0;
            end
        end
        suppress = !bus.digit_mask[idx_q] || (bus.lz_en && idx_q != '0 && lz_zero);
    end

    // Next-state: slot/digit counters, blank/on phase, value handoff and output images.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        state_d    = state_q;
        shadow_d   = shadow_q;
        pend_reg_d = pend_reg_q;
        pending_d  = pending_q;
        seg_d      = SEG_BLANK;
        an_d       = ANODE_OFF;
        fd_d       = 1'b0;
        wrap       = 1'b0;

        if (bus.en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + IDX_W'(1);
                wrap  = (idx_q == IDX_W'(NUM_DIGITS - 1));
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
            idx_d = '0;
        end

        state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_ON;
        fd_d    = wrap;

        // A frame starts on the digit wrap or on the first enabled cycle.
        if ((wrap || (bus.en && !en_q)) && pending_q) begin
            shadow_d  = pend_reg_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            pend_reg_d = bus.value;
            pending_d  = 1'b1;
        end

        if (bus.en && state_q == ST_ON && !suppress) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = glyph;
        end
    end

    // State, data and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= ST_BLANK;
            shadow_q   <= '0;
            pend_reg_q <= '0;
            pending_q  <= 1'b0;
            en_q       <= 1'b0;
            seg_q      <= SEG_BLANK;
            an_q       <= ANODE_OFF;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            pend_reg_q <= pend_reg_d;
            pending_q  <= pending_d;
            en_q       <= bus.en;
            seg_q      <= seg_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.segments   = seg_q;
    assign bus.anodes     = an_q;
    assign bus.frame_done = fd_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_seven_seg_scanner;

    localparam int unsigned RDIV = 8;
    localparam int unsigned BLK  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    seven_seg_scanner_if bus_if ();

    seven_seg_scanner #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".an"},  32'(bus_if.anodes),     32'h0FF);
        check_eq({tag, ".seg"}, 32'(bus_if.segments),   32'h07F);
        check_eq({tag, ".fd"},  32'(bus_if.frame_done), 32'h0);
    endtask

    // Runs n cycles of a frame from slot start. gl holds the hand-computed glyph of
    // digit i at [7*i +: 7], lit marks which digits should light. Loads happen at
    // cycles la/lb; p0 is pending at frame start, rise marks the first enabled cycle.
    task automatic run_frame(input string tag, input logic [55:0] gl, input logic [7:0] lit,
                             input int n, input int la, input logic [31:0] va,
                             input int lb, input logic [31:0] vb,
                             input bit rise, input bit p0);
        bit p;
        p = p0;
        for (int c = 0; c < n; c++) begin
            int slot;
            int cy;
            logic [7:0] ea;
            logic [6:0] es;
            slot = c / 8;
            cy   = c % 8;
            bus_if.load  = (c == la) || (c == lb);
            bus_if.value = (c == lb) ? vb : va;
            tick();
            if (cy >= int'(BLK) && lit[slot]) begin
                ea = ~(8'(1) << slot);
                es = gl[7*slot +: 7];
            end else begin
                ea = 8'hFF;
                es = 7'h7F;
            end
            check_eq($sformatf("%s.an[%0d]", tag, c),  32'(bus_if.anodes),     32'(ea));
            check_eq($sformatf("%s.seg[%0d]", tag, c), 32'(bus_if.segments),   32'(es));
            check_eq($sformatf("%s.fd[%0d]", tag, c),  32'(bus_if.frame_done), 32'(c == 63));
            if ((rise && c == 0) || c == 63) p = 1'b0;
            if (c == la || c == lb) p = 1'b1;
            check_eq($sformatf("%s.pend[%0d]", tag, c), 32'(bus_if.pending), 32'(p));
        end
        bus_if.load = 1'b0;
    endtask

    initial begin
        bus_if.en         = 1'b0;
        bus_if.load       = 1'b0;
        bus_if.value      = 32'h0;
        bus_if.digit_mask = 8'hFF;
        bus_if.lz_en      = 1'b0;

        #2 rst_n = 1'b0;
        tick();
        tick();
        check_idle("rst");
        check_eq("rst.pend", 32'(bus_if.pending), 32'h0);
        rst_n = 1'b1;
        tick();

        // Frame 0 shows reset shadow; value 8 waits as pending.
        bus_if.en = 1'b1;
        run_frame("f0", {8{7'h40}}, 8'hFF, 64, 0, 32'h0000_0008, -1, 32'h0, 1'b1, 1'b0);
        // Digit 0 shows 8; queue the mixed pattern.
        run_frame("f1", {{7{7'h40}}, 7'h00}, 8'hFF, 64, 10, 32'h1234_ABCF, -1, 32'h0, 1'b0, 1'b0);
        // F,C,B,A,4,3,2,1 on digits 0..7.
        run_frame("f2", {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h0E}, 8'hFF,
                  64, 20, 32'h0000_00F0, -1, 32'h0, 1'b0, 1'b0);
        // Leading-zero suppression: only digits 0 and 1 lit.
        bus_if.lz_en = 1'b1;
        run_frame("f3", {{6{7'h7F}}, 7'h0E, 7'h40}, 8'h03, 64, 30, 32'h0, -1, 32'h0, 1'b0, 1'b0);
        // All-zero shadow still shows digit 0.
        run_frame("f4", {{7{7'h7F}}, 7'h40}, 8'h01, 64, 50, 32'h9876_5432, -1, 32'h0, 1'b0, 1'b0);
        // Two loads mid-frame; display holds the old value for the whole frame.
        bus_if.lz_en = 1'b0;
        run_frame("f5", {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24}, 8'hFF,
                  64, 24, 32'h1111_1111, 40, 32'h2222_2222, 1'b0, 1'b0);
        // Second load wins; digit mask applied; load coincides with the wrap.
        bus_if.digit_mask = 8'hA5;
        run_frame("f6", {8{7'h24}}, 8'hA5, 64, 10, 32'hAAAA_AAAA, 63, 32'hBBBB_BBBB, 1'b0, 1'b0);
        bus_if.digit_mask = 8'hFF;
        run_frame("f7", {8{7'h08}}, 8'hFF, 64, -1, 32'h0, -1, 32'h0, 1'b0, 1'b1);
        run_frame("f8", {8{7'h03}}, 8'hFF, 64, -1, 32'h0, -1, 32'h0, 1'b0, 1'b0);

        // Scan disabled: outputs idle, load still captured.
        bus_if.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.load  = (i == 0);
            bus_if.value = 32'hCCCC_CCCC;
            tick();
            check_idle($sformatf("dis[%0d]", i));
            check_eq($sformatf("dis.pend[%0d]", i), 32'(bus_if.pending), 32'h1);
        end
        bus_if.load = 1'b0;

        // Re-enable transfers the pending value immediately; stop mid slot 4.
        bus_if.en = 1'b1;
        run_frame("f9", {8{7'h46}}, 8'hFF, 36, 5, 32'hDDDD_DDDD, -1, 32'h0, 1'b1, 1'b1);
        check_eq("pre.an", 32'(bus_if.anodes), 32'h0EF);
        rst_n = 1'b0;
        #1;
        check_idle("arst");
        check_eq("arst.pend", 32'(bus_if.pending), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        // Pending value discarded: frame shows cleared shadow from slot start.
        run_frame("f10", {8{7'h40}}, 8'hFF, 64, -1, 32'h0, -1, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
